// File: rtl/rs232_tx_piso.sv
// RS-232 serial transmitter: start bit, LSB-first data, optional even parity, stop bit(s).
// Optional parity bit enabled by defining RS232_TX_PARITY_EN.
module rs232_tx_piso #(
    parameter int unsigned Width    = 8,
    parameter int unsigned BaudDiv  = 434,
    parameter int unsigned StopBits = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [Width-1:0] din_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned BaudW = $clog2(BaudDiv);
    localparam int unsigned BitW  = $clog2(Width + 1);

    localparam logic [BaudW-1:0] BaudLast = BaudW'(BaudDiv - 1);
    localparam logic [BitW-1:0]  DataLast = BitW'(Width - 1);
    localparam logic [BitW-1:0]  StopLast = BitW'(StopBits - 1);

`ifdef RS232_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e             state_q, state_d;
    logic [Width-1:0]   shreg_q, shreg_d;
    logic [BaudW-1:0]   baud_q, baud_d;
    logic [BitW-1:0]    bit_q, bit_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bit_end;
`ifdef RS232_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    assign bit_end = (baud_q == BaudLast);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef RS232_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != StIdle) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start_i) begin
                    shreg_d = din_i;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StStart;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef RS232_TX_PARITY_EN
                    parity_d = ^din_i;
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    tx_d    = shreg_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == DataLast) begin
                        // Bit counter is reused to count stop bits.
                        bit_d = '0;
`ifdef RS232_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = parity_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shreg_d[0];
                    end
                end
            end
`ifdef RS232_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (bit_q == StopLast) begin
                        state_d = StIdle;
                        bit_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            shreg_q <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef RS232_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef RS232_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_rs232_tx_piso.sv
// Bench for rs232_tx_piso: frame-timer reference model plus directed frame scenarios.
module tb_rs232_tx_piso;

    localparam int W = 8;
    localparam int B = 4;
    localparam int S = 1;
`ifdef RS232_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = 1 + W + P + S;
    localparam int FL = NB * B;

    logic         clk_i   = 1'b0;
    logic         rst_ni  = 1'b1;
    logic         start_i = 1'b0;
    logic [W-1:0] din_i   = '0;
    logic         tx_o, busy_o, done_o;

    int checks = 0;
    int errors = 0;

    logic tx_s   [0:255];
    logic busy_s [0:255];
    logic done_s [0:255];
    int   idx;

    rs232_tx_piso #(
        .Width   (W),
        .BaudDiv (B),
        .StopBits(S)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start_i(start_i),
        .din_i  (din_i),
        .tx_o   (tx_o),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: a frame is a timer running 0..FL-1; line bit = time / B.
    logic         m_active, m_done;
    int           m_t;
    logic [W-1:0] m_word;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_t      <= 0;
            m_word   <= '0;
        end else begin
            m_done <= 1'b0;
            if (!m_active) begin
                if (start_i) begin
                    m_active <= 1'b1;
                    m_t      <= 0;
                    m_word   <= din_i;
                end
            end else if (m_t == FL - 1) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    function automatic logic exp_tx();
        int k;
        if (!m_active) return 1'b1;
        k = m_t / B;
        if (k == 0) return 1'b0;
        if (k <= W) return m_word[k-1];
        if (P == 1 && k == W + 1) return ^m_word;
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        chk("model_tx", {31'd0, tx_o}, {31'd0, exp_tx()});
        chk("model_busy", {31'd0, busy_o}, {31'd0, m_active});
        chk("model_done", {31'd0, done_o}, {31'd0, m_done});
    end

    task automatic sample(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            tx_s[idx]   = tx_o;
            busy_s[idx] = busy_o;
            done_s[idx] = done_o;
            idx++;
        end
    endtask

    function automatic int cnt_busy(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) if (busy_s[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int cnt_done(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) if (done_s[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int cnt_tx_hi(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) if (tx_s[i] === 1'b1) c++;
        return c;
    endfunction

    // Sample the middle of each data bit of a frame whose start bit begins at base.
    function automatic logic [W-1:0] decode(input int base);
        logic [W-1:0] w;
        for (int i = 0; i < W; i++) w[i] = tx_s[base + B * (i + 1) + B / 2];
        return w;
    endfunction

    task automatic send(input logic [W-1:0] d, input int n);
        start_i = 1'b1;
        din_i   = d;
        sample(1);
        start_i = 1'b0;
        sample(n);
    endtask

    initial begin
        // Reset held with start asserted: line idle, nothing starts.
        #1 rst_ni = 1'b0;
        start_i = 1'b1;
        din_i   = 8'h55;
        idx = 0;
        sample(5);
        chk("rst_busy_cnt", cnt_busy(0, 4), 0);
        chk("rst_done_cnt", cnt_done(0, 4), 0);
        chk("rst_tx_hi_cnt", cnt_tx_hi(0, 4), 5);
        start_i = 1'b0;
        rst_ni  = 1'b1;
        sample(3);
        chk("post_rst_busy", cnt_busy(5, 7), 0);

        // Single 0x55 frame with a rejected start pulse carrying 0xFF mid-frame.
        idx = 0;
        start_i = 1'b1;
        din_i   = 8'h55;
        sample(1);
        start_i = 1'b0;
        sample(10);
        start_i = 1'b1;
        din_i   = 8'hFF;
        sample(1);
        start_i = 1'b0;
        din_i   = 8'h00;
        sample(50);
        chk("f55_first_tx", tx_s[0], 1'b0);
        chk("f55_start_bit", tx_s[2], 1'b0);
        chk("f55_word", decode(0), 8'h55);
        chk("f55_bit1", tx_s[6], 1'b1);
        chk("f55_stop", tx_s[B * (NB - 1) + 2], 1'b1);
        chk("f55_busy_len", cnt_busy(0, 61), FL);
        chk("f55_done_cnt", cnt_done(0, 61), 1);
        chk("f55_done_pos", done_s[FL], 1'b1);
        chk("f55_busy_at_done", busy_s[FL], 1'b0);

        // Back-to-back with start held high: 0xA3 then 0x3C, one idle clock between.
        idx = 0;
        start_i = 1'b1;
        din_i   = 8'hA3;
        sample(5);
        din_i = 8'h3C;
        sample(FL + 5);
        start_i = 1'b0;
        sample(FL + 10);
        chk("b2b_word0", decode(0), 8'hA3);
        chk("b2b_word1", decode(FL + 1), 8'h3C);
        chk("b2b_stop_end", tx_s[FL - 1], 1'b1);
        chk("b2b_idle_gap", tx_s[FL], 1'b1);
        chk("b2b_next_start", tx_s[FL + 1], 1'b0);
        chk("b2b_gap_busy", busy_s[FL], 1'b0);
        chk("b2b_done_cnt", cnt_done(0, idx - 1), 2);
        chk("b2b_busy_total", cnt_busy(0, idx - 1), 2 * FL);

        // Reset asserted between clock edges during data bit 3 (0xF0 bit 3 is 0).
        idx = 0;
        send(8'hF0, 17);
        chk("mid_tx_before_rst", {31'd0, tx_o}, 32'd0);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_tx_async", {31'd0, tx_o}, 32'd1);
        chk("mid_busy_async", {31'd0, busy_o}, 32'd0);
        sample(3);
        rst_ni = 1'b1;
        sample(FL + 5);
        chk("mid_no_done", cnt_done(18, idx - 1), 0);
        chk("mid_no_busy", cnt_busy(18, idx - 1), 0);
        idx = 0;
        send(8'hC6, FL + 4);
        chk("mid_new_word", decode(0), 8'hC6);
        chk("mid_new_len", cnt_busy(0, idx - 1), FL);
        chk("mid_new_done", cnt_done(0, idx - 1), 1);

`ifdef RS232_TX_PARITY_EN
        idx = 0;
        send(8'h07, FL + 4);
        chk("par07_word", decode(0), 8'h07);
        chk("par07_bit", tx_s[B * (W + 1) + 2], 1'b1);
        chk("par07_len", cnt_busy(0, idx - 1), 44);
        idx = 0;
        send(8'h03, FL + 4);
        chk("par03_word", decode(0), 8'h03);
        chk("par03_bit", tx_s[B * (W + 1) + 2], 1'b0);
        chk("par03_len", cnt_busy(0, idx - 1), 44);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
